// File: rtl/tmds_channel_decoder_if.sv
// Signal bundle between a 1:10 deserializer channel and its TMDS decoder.
interface tmds_channel_decoder_if;
    // Streaming link with no handshake: the slave takes raw on every clock and
    // presents one decoded symbol per clock; there is no valid/ready back-pressure.
    logic [9:0] raw;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;
    logic [3:0] terc4;
    logic       terc4_valid;
    logic       fsm_state;

    modport master (output raw,
                    input  data, ctrl, de, locked, offset, terc4, terc4_valid, fsm_state);
    modport slave  (input  raw,
                    output data, ctrl, de, locked, offset, terc4, terc4_valid, fsm_state);
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: bit-slip alignment on control-token runs, then symbol decode.
// Optional TERC4 data-island decode is built when TMDS_CHANNEL_DECODER_TERC4_EN is defined.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT = 8,
    parameter int TIMEOUT    = 4096
) (
    input logic clk,
    input logic rst,
    tmds_channel_decoder_if.slave bus
);
    localparam int TW = $clog2(LOCK_COUNT + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t         state;
    logic           locked;
    logic [3:0]     offset;
    logic [TW-1:0]  tok_cnt;
    logic [IW-1:0]  idle_cnt;
    logic           flush;
    logic [9:0]     prev;
    logic [9:0]     sym1;
    logic [19:0]    window;
    logic [9:0]     sym;
    logic           tok_hit;
    logic [1:0]     tok_val;
    logic [7:0]     d;
    logic [7:0]     dec;
    logic [7:0]     data_r;
    logic [1:0]     ctrl_r;
    logic           de_r;

    assign window = {bus.raw, prev};

    always_comb begin
        sym = window[9:0];
        for (int i = 1; i < 10; i++)
            if (offset == 4'(i)) sym = window[i +: 10];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            sym1 <= '0;
        end else begin
            prev <= bus.raw;
            sym1 <= sym;
        end
    end

    always_comb begin
        tok_hit = 1'b1;
        tok_val = 2'b00;
        case (sym1)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        tok_hit = 1'b0;
        endcase
    end

    always_comb begin
        d      = sym1[9] ? ~sym1[7:0] : sym1[7:0];
        dec    = '0;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++)
            dec[i] = sym1[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_r   <= 1'b0;
            data_r <= '0;
            ctrl_r <= '0;
        end else if (tok_hit) begin
            de_r   <= 1'b0;
            data_r <= '0;
            ctrl_r <= tok_val;
        end else begin
            de_r   <= 1'b1;
            data_r <= dec;
        end
    end

    // After a slip, stage 1 still holds a symbol cut at the old offset; skip it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            offset   <= '0;
            tok_cnt  <= '0;
            idle_cnt <= '0;
            flush    <= 1'b0;
        end else begin
            flush <= 1'b0;
            if (!flush) begin
                if (idle_cnt == IW'(TIMEOUT)) begin
                    state    <= SEARCH;
                    locked   <= 1'b0;
                    offset   <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    tok_cnt  <= '0;
                    idle_cnt <= '0;
                    flush    <= 1'b1;
                end else if (tok_hit) begin
                    idle_cnt <= '0;
                    if (state == SEARCH) begin
                        if (tok_cnt != TW'(LOCK_COUNT)) tok_cnt <= tok_cnt + TW'(1);
                        if (tok_cnt == TW'(LOCK_COUNT - 1)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end else begin
                    tok_cnt <= '0;
                    if (idle_cnt != IW'(TIMEOUT)) idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

    assign bus.de        = de_r & locked;
    assign bus.data      = locked ? data_r : 8'h00;
    assign bus.ctrl      = locked ? ctrl_r : 2'b00;
    assign bus.locked    = locked;
    assign bus.offset    = offset;
    assign bus.fsm_state = state;

`ifdef TMDS_CHANNEL_DECODER_TERC4_EN
    logic       t4_hit;
    logic [3:0] t4_val;
    logic [3:0] t4_r;
    logic       t4v_r;

    always_comb begin
        t4_hit = 1'b1;
        t4_val = 4'h0;
        case (sym1)
            10'b1010011100: t4_val = 4'h0;
            10'b1001100011: t4_val = 4'h1;
            10'b1011100100: t4_val = 4'h2;
            10'b1011100010: t4_val = 4'h3;
            10'b0101110001: t4_val = 4'h4;
            10'b0100011110: t4_val = 4'h5;
            10'b0110001110: t4_val = 4'h6;
            10'b0100111100: t4_val = 4'h7;
            10'b1011001100: t4_val = 4'h8;
            10'b0100111001: t4_val = 4'h9;
            10'b0110011100: t4_val = 4'hA;
            10'b1011000110: t4_val = 4'hB;
            10'b1010001110: t4_val = 4'hC;
            10'b1001110001: t4_val = 4'hD;
            10'b0101100011: t4_val = 4'hE;
            10'b1011000011: t4_val = 4'hF;
            default:        t4_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t4_r  <= '0;
            t4v_r <= 1'b0;
        end else begin
            t4_r  <= t4_hit ? t4_val : 4'h0;
            t4v_r <= t4_hit;
        end
    end

    assign bus.terc4       = locked ? t4_r : 4'h0;
    assign bus.terc4_valid = t4v_r & locked;
`else
    assign bus.terc4       = 4'h0;
    assign bus.terc4_valid = 1'b0;
`endif
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: a bit-level shifter misaligns the symbol stream.
module tb_tmds_channel_decoder;
    localparam int LOCK_COUNT = 8;
    localparam int TIMEOUT    = 4096;
    localparam int LINE       = 1650;
    localparam int BLANK      = 370;
    localparam int W          = 17;
    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK2 = 10'b0101010100;
    localparam logic [9:0] TOK3 = 10'b1010101011;
`ifdef TMDS_CHANNEL_DECODER_TERC4_EN
    localparam bit T4_EN = 1'b1;
`else
    localparam bit T4_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmds_channel_decoder_if bus();

    tmds_channel_decoder #(.LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic bq[$];
    int line_pos = 0;
    logic [1:0] last_ctrl = 2'b00;

    function automatic logic [7:0] tmds_dec(logic [9:0] q);
        logic [7:0] dd, o;
        dd = q[9] ? ~q[7:0] : q[7:0];
        o[0] = dd[0];
        for (int i = 1; i < 8; i++) o[i] = q[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
        return o;
    endfunction

    function automatic logic [2:0] token_of(logic [9:0] q);
        case (q)
            10'b1101010100: return 3'b100;
            10'b0010101011: return 3'b101;
            10'b0101010100: return 3'b110;
            10'b1010101011: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_shift(int s);
        bq.delete();
        repeat (s) bq.push_back(1'b0);
    endtask

    // Sends one symbol through the bit shifter; the result leaves the DUT two sends later.
    task automatic send(logic [9:0] s, bit chk, logic [3:0] t4, bit t4v);
        logic [9:0] raw_w;
        logic [2:0] tk;
        logic [W-1:0] e;
        for (int i = 0; i < 10; i++) bq.push_back(s[i]);
        for (int i = 0; i < 10; i++) raw_w[i] = bq.pop_front();
        bus.raw = raw_w;
        tk = token_of(s);
        if (tk[2]) begin
            last_ctrl = tk[1:0];
            e = {chk, 1'b0, tk[1:0], 8'h00, t4v, t4};
        end else begin
            e = {chk, 1'b1, last_ctrl, tmds_dec(s), t4v, t4};
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            if (e[W-1])
                check("sym", {bus.de, bus.ctrl, bus.data, bus.terc4_valid, bus.terc4}, 32'(e[W-2:0]));
        end
    endtask

    task automatic line_sym();
        send((line_pos < BLANK) ? TOK0 : 10'h100, 1'b0, 4'h0, 1'b0);
        line_pos = (line_pos == LINE - 1) ? 0 : line_pos + 1;
    endtask

    task automatic wait_lock(int budget, string tag);
        int n = 0;
        while (!bus.locked && n < budget) begin
            line_sym();
            n++;
        end
        check(tag, bus.locked, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.raw = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        set_shift(0);
        last_ctrl = 2'b00;
        line_pos = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic lost;
        logic [9:0] w;

        // Reset state and lock on a continuous token run at offset 0
        do_reset();
        check("rst_locked", bus.locked, 0);
        check("rst_offset", bus.offset, 0);
        check("rst_de", bus.de, 0);
        check("rst_data", bus.data, 0);
        check("rst_ctrl", bus.ctrl, 0);
        check("rst_t4v", bus.terc4_valid, 0);
        check("rst_state", bus.fsm_state, 0);
        repeat (LOCK_COUNT + 1) send(TOK0, 1'b0, 4'h0, 1'b0);
        check("t1_not_yet", bus.locked, 0);
        send(TOK0, 1'b0, 4'h0, 1'b0);
        check("t1_lock", bus.locked, 1);
        check("t1_offset", bus.offset, 0);
        check("t1_de", bus.de, 0);
        check("t1_ctrl", bus.ctrl, 0);
        check("t1_state", bus.fsm_state, 1);

        // 720p-like line stream shifted by 3 bits
        do_reset();
        set_shift(3);
        wait_lock(3 * TIMEOUT + 2000, "t2_lock");
        check("t2_offset", bus.offset, 3);
        lost = 1'b0;
        repeat (2 * LINE) begin
            line_sym();
            if (!bus.locked) lost = 1'b1;
        end
        check("t2_hold", lost, 0);

        // Decoded data, held ctrl and TERC4 through the scoreboard
        repeat (4) send(TOK2, 1'b1, 4'h0, 1'b0);
        send(10'h200, 1'b1, 4'h0, 1'b0);
        send(10'h100, 1'b1, 4'h0, 1'b0);
        send(10'b1001100011, 1'b1, T4_EN ? 4'b0001 : 4'b0000, T4_EN);
        send(TOK3, 1'b1, 4'h0, 1'b0);
        send(10'h200, 1'b1, 4'h0, 1'b0);
        send(10'b1011000011, 1'b1, T4_EN ? 4'b1111 : 4'b0000, T4_EN);
        send(10'b1010011100, 1'b1, 4'b0000, T4_EN);
        repeat (6) begin
            w[9:8] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            w[7:0] = 8'($urandom_range(0, 255));
            send(w, 1'b1, 4'h0, 1'b0);
        end
        repeat (3) send(TOK0, 1'b1, 4'h0, 1'b0);

        // Idle timeout while locked: offset 3 -> 4
        repeat (TIMEOUT - 2) send(10'h100, 1'b0, 4'h0, 1'b0);
        check("t4_still_locked", bus.locked, 1);
        repeat (6) send(10'h100, 1'b0, 4'h0, 1'b0);
        check("t4_unlock", bus.locked, 0);
        check("t4_offset", bus.offset, 4);
        check("t4_de", bus.de, 0);
        check("t4_data", bus.data, 0);

        // Relock at offset 5, then reset mid-operation
        set_shift(5);
        line_pos = 0;
        wait_lock(TIMEOUT + 2 * LINE + 100, "t5_lock");
        check("t5_offset", bus.offset, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_locked", bus.locked, 0);
        check("t5_rst_offset", bus.offset, 0);
        check("t5_rst_de", bus.de, 0);
        check("t5_rst_data", bus.data, 0);
        rst = 1'b0;
        exp_q.delete();

        // Walk to offset 9, then time out and wrap to 0
        set_shift(9);
        line_pos = 0;
        wait_lock(9 * TIMEOUT + 2 * LINE + 200, "t9_lock");
        check("t9_offset", bus.offset, 9);
        repeat (TIMEOUT + 4) send(10'h100, 1'b0, 4'h0, 1'b0);
        check("t9_unlock", bus.locked, 0);
        check("t9_wrap", bus.offset, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
